// File: rtl/alu_issue_ctrl.sv
// Issue/control stage in front of the 16-bit ALU: fetches operands from an 8x16 register file,
// sequences IDLE->DECODE->EXEC->WB per instruction, writes back the result and owns the carry flag.
module alu_issue_ctrl #(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_pass,
    output logic          alu_add,
    output logic          alu_mult,
    output logic          alu_stcrry,
    output logic          alu_clrcrry,
    input  logic [DW-1:0] alu_result,
    output logic          carry,
    output logic          done,
    output logic          illegal,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [1:0]    dbg_state
);

    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // instr must be held until then and is never re-sampled afterwards.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PASS = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_SETC = 4'd4;
    localparam logic [3:0] OP_CLRC = 4'd5;
    localparam logic [3:0] OP_LDI  = 4'd6;

    state_t        r_state;
    state_t        w_next;
    logic          r_ready;
    logic [15:0]   r_instr;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [DW-1:0] r_result;
    logic          r_carry;
    logic [DW-1:0] r_regs [NREGS];

    logic [3:0]    w_op;
    logic [2:0]    w_rd;
    logic [2:0]    w_ra;
    logic [2:0]    w_rb;
    logic [DW:0]   w_sum;
    logic          w_accept;
    logic          w_wr_en;
    logic [DW-1:0] w_wr_data;

    assign w_op     = r_instr[15:12];
    assign w_rd     = r_instr[11:9];
    assign w_ra     = r_instr[8:6];
    assign w_rb     = r_instr[5:3];
    assign w_accept = instr_valid && r_ready;
    // Carry comes from the latched operands, not from the ALU.
    assign w_sum    = {1'b0, r_alu_a} + {1'b0, r_alu_b};

    always_comb begin
        w_next      = r_state;
        alu_pass    = 1'b0;
        alu_add     = 1'b0;
        alu_mult    = 1'b0;
        alu_stcrry  = 1'b0;
        alu_clrcrry = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                w_next      = S_WB;
                alu_pass    = (w_op == OP_PASS);
                alu_add     = (w_op == OP_ADD);
                alu_mult    = (w_op == OP_MUL);
                alu_stcrry  = (w_op == OP_SETC);
                alu_clrcrry = (w_op == OP_CLRC);
            end
            S_WB: begin
                w_next  = S_IDLE;
                done    = 1'b1;
                illegal = (w_op > OP_LDI);
                w_wr_en = (w_op == OP_PASS) || (w_op == OP_ADD) ||
                          (w_op == OP_MUL)  || (w_op == OP_LDI);
            end
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_wr_data = (w_op == OP_LDI) ? {{(DW-9){1'b0}}, r_instr[8:0]} : r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b0;
            r_instr  <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_state <= w_next;
            // Registered ready: low during reset, high from the first edge after release.
            r_ready <= (w_next == S_IDLE);
            if (r_state == S_IDLE && w_accept) r_instr <= instr;
            if (r_state == S_DECODE) begin
                r_alu_a <= r_regs[w_ra];
                r_alu_b <= r_regs[w_rb];
            end
            if (r_state == S_EXEC) r_result <= alu_result;
            if (w_wr_en) r_regs[w_rd] <= w_wr_data;
            if (r_state == S_WB) begin
                case (w_op)
                    OP_ADD:  r_carry <= w_sum[DW];
                    OP_SETC: r_carry <= 1'b1;
                    OP_CLRC: r_carry <= 1'b0;
                    default: r_carry <= r_carry;
                endcase
            end
        end
    end

    assign instr_ready = r_ready;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign carry       = r_carry;
    assign dbg_data    = r_regs[dbg_addr];
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU model; checks timing, writeback, carry,
// illegal handling and asynchronous reset abort against hand-computed values.
module tb_alu_issue_ctrl;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_PASS = 5'b10000;
    localparam logic [4:0] S_ADD  = 5'b01000;
    localparam logic [4:0] S_MUL  = 5'b00100;
    localparam logic [4:0] S_SETC = 5'b00010;
    localparam logic [4:0] S_CLRC = 5'b00001;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_pass, alu_add, alu_mult, alu_stcrry, alu_clrcrry;
    logic [15:0] alu_result;
    logic        carry;
    logic        done;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [1:0]  dbg_state;
    logic [4:0]  strb;

    int n_checks;
    int n_fail;

    alu_issue_ctrl #(.NREGS(8), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_pass(alu_pass), .alu_add(alu_add), .alu_mult(alu_mult),
        .alu_stcrry(alu_stcrry), .alu_clrcrry(alu_clrcrry),
        .alu_result(alu_result), .carry(carry), .done(done), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    // Behavioural ALU: the DUT samples the result only while a strobe is high.
    logic [15:0] w_mul;
    assign w_mul      = alu_a[7:0] * alu_b[7:0];
    assign alu_result = alu_pass ? alu_a :
                        alu_add  ? alu_a + alu_b :
                        alu_mult ? w_mul : 16'h0000;
    assign strb = {alu_pass, alu_add, alu_mult, alu_stcrry, alu_clrcrry};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 3'b000};
    endfunction

    function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [8:0] imm);
        return {4'h6, rd, imm};
    endfunction

    task automatic check_reg(input logic [2:0] a, input logic [15:0] e, input string tag);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, e);
    endtask

    // Called near a negedge; walks one instruction through all four states.
    task automatic issue(input logic [15:0] ins, input logic [4:0] exp_strb,
                         input logic exp_ill, input string tag);
        int waits;
        waits = 0;
        instr = ins;
        instr_valid = 1'b1;
        while (!instr_ready && waits < 16) begin
            @(negedge clk);
            waits++;
        end
        chk({tag, "_accept_timeout"}, 32'(waits >= 16), 0);
        @(negedge clk);
        instr_valid = 1'b0;
        chk({tag, "_dec_strb"}, strb, S_NONE);
        chk({tag, "_dec_ready"}, instr_ready, 0);
        @(negedge clk);
        chk({tag, "_exe_strb"}, strb, exp_strb);
        chk({tag, "_exe_done"}, done, 0);
        @(negedge clk);
        chk({tag, "_wb_strb"}, strb, S_NONE);
        chk({tag, "_wb_done"}, done, 1);
        chk({tag, "_wb_illegal"}, illegal, exp_ill);
        @(negedge clk);
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_ready"}, instr_ready, 1);
    endtask

    initial begin
        int acc[$];
        int n_done;
        int n_ill;
        int n_pairbad;
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 3'd0;

        repeat (3) @(negedge clk);
        chk("rst_ready", instr_ready, 0);
        chk("rst_carry", carry, 0);
        chk("rst_strb", strb, S_NONE);
        chk("rst_done", done, 0);
        for (int i = 0; i < 8; i++) check_reg(3'(i), 16'h0000, "rst_reg");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_before_edge", instr_ready, 0);
        @(negedge clk);
        chk("rel_ready_after_edge", instr_ready, 1);

        issue(enc_ldi(3'd1, 9'h1FF), S_NONE, 1'b0, "ldi_r1");
        check_reg(3'd1, 16'h01FF, "r1_ldi");
        issue(enc_ldi(3'd2, 9'h0FF), S_NONE, 1'b0, "ldi_r2");
        check_reg(3'd2, 16'h00FF, "r2_ldi");
        issue(enc(4'h2, 3'd3, 3'd1, 3'd2), S_ADD, 1'b0, "add_r3");
        check_reg(3'd3, 16'h02FE, "r3_add");
        chk("add_r3_carry", carry, 0);

        // r4: 0x1FF doubled seven times is 0xFF80; adding 0x7F gives 0xFFFF.
        issue(enc_ldi(3'd4, 9'h1FF), S_NONE, 1'b0, "ldi_r4");
        for (int i = 0; i < 7; i++) issue(enc(4'h2, 3'd4, 3'd4, 3'd4), S_ADD, 1'b0, "dbl_r4");
        check_reg(3'd4, 16'hFF80, "r4_dbl");
        issue(enc_ldi(3'd6, 9'h07F), S_NONE, 1'b0, "ldi_r6");
        issue(enc(4'h2, 3'd4, 3'd4, 3'd6), S_ADD, 1'b0, "add_ffff");
        check_reg(3'd4, 16'hFFFF, "r4_ffff");
        chk("ffff_carry", carry, 0);
        issue(enc_ldi(3'd5, 9'h001), S_NONE, 1'b0, "ldi_r5");
        issue(enc(4'h2, 3'd4, 3'd4, 3'd5), S_ADD, 1'b0, "add_wrap");
        check_reg(3'd4, 16'h0000, "r4_wrap");
        chk("wrap_carry", carry, 1);
        issue(enc(4'h5, 3'd0, 3'd0, 3'd0), S_CLRC, 1'b0, "clrc");
        chk("clrc_carry", carry, 0);
        issue(enc(4'h4, 3'd0, 3'd0, 3'd0), S_SETC, 1'b0, "setc");
        chk("setc_carry", carry, 1);

        issue(enc(4'h1, 3'd0, 3'd3, 3'd0), S_PASS, 1'b0, "pass_r0");
        check_reg(3'd0, 16'h02FE, "r0_pass");
        chk("pass_carry", carry, 1);
        issue(16'h0000, S_NONE, 1'b0, "nop");
        check_reg(3'd0, 16'h02FE, "r0_nop");

        // r1 = 0x120<<4 + 0xFF = 0x12FF; r2 = 0x1A0<<5 + 3 = 0x3403.
        issue(enc_ldi(3'd1, 9'h120), S_NONE, 1'b0, "ldi_r1b");
        for (int i = 0; i < 4; i++) issue(enc(4'h2, 3'd1, 3'd1, 3'd1), S_ADD, 1'b0, "dbl_r1");
        issue(enc_ldi(3'd0, 9'h0FF), S_NONE, 1'b0, "ldi_r0ff");
        issue(enc(4'h2, 3'd1, 3'd1, 3'd0), S_ADD, 1'b0, "add_r1");
        check_reg(3'd1, 16'h12FF, "r1_12ff");
        issue(enc_ldi(3'd2, 9'h1A0), S_NONE, 1'b0, "ldi_r2b");
        for (int i = 0; i < 5; i++) issue(enc(4'h2, 3'd2, 3'd2, 3'd2), S_ADD, 1'b0, "dbl_r2");
        issue(enc_ldi(3'd0, 9'h003), S_NONE, 1'b0, "ldi_r0_3");
        issue(enc(4'h2, 3'd2, 3'd2, 3'd0), S_ADD, 1'b0, "add_r2");
        check_reg(3'd2, 16'h3403, "r2_3403");
        issue(enc(4'h4, 3'd0, 3'd0, 3'd0), S_SETC, 1'b0, "setc2");
        issue(enc(4'h3, 3'd6, 3'd1, 3'd2), S_MUL, 1'b0, "mul_r6");
        check_reg(3'd6, 16'h02FD, "r6_mul");
        chk("mul_carry", carry, 1);

        // Illegal opcode with valid held high: accepted every 4 cycles.
        @(negedge clk);
        n_done    = 0;
        n_ill     = 0;
        n_pairbad = 0;
        instr       = 16'hA000;
        instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (instr_ready) acc.push_back(i);
            if (done) n_done++;
            if (illegal) n_ill++;
            if (done !== illegal) n_pairbad++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("ill_accepts", acc.size(), 3);
        chk("ill_spacing", (acc.size() >= 2) ? 32'(acc[1] - acc[0]) : 32'd0, 4);
        chk("ill_done_cnt", n_done, 3);
        chk("ill_pulse_cnt", n_ill, 3);
        chk("ill_pair", n_pairbad, 0);
        check_reg(3'd6, 16'h02FD, "ill_r6");
        check_reg(3'd0, 16'h0003, "ill_r0");
        chk("ill_carry", carry, 1);

        // Abort ADD r7 in EXEC with an asynchronous reset.
        @(negedge clk);
        instr       = enc(4'h2, 3'd7, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_exec_add", alu_add, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_strb", strb, S_NONE);
        chk("abort_state", dbg_state, 0);
        chk("abort_ready", instr_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_done_after", done, 0);
        check_reg(3'd7, 16'h0000, "abort_r7");
        check_reg(3'd1, 16'h0000, "abort_r1");
        chk("abort_carry", carry, 0);
        issue(enc_ldi(3'd7, 9'h055), S_NONE, 1'b0, "post_ldi");
        check_reg(3'd7, 16'h0055, "post_r7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
